// File: rtl/fix_pkg.sv
// Shared constants and types for the FIX MsgType classifier: message classes,
// error codes, FSM states and the per-message result record.
package fix_pkg;

  typedef logic [3:0] msg_type_t;

  localparam msg_type_t TYPE_UNKNOWN    = 4'd0;
  localparam msg_type_t TYPE_LOGON      = 4'd1;
  localparam msg_type_t TYPE_HEARTBEAT  = 4'd2;
  localparam msg_type_t TYPE_TEST_REQ   = 4'd3;
  localparam msg_type_t TYPE_RESEND_REQ = 4'd4;
  localparam msg_type_t TYPE_REJECT     = 4'd5;
  localparam msg_type_t TYPE_SEQ_RESET  = 4'd6;
  localparam msg_type_t TYPE_LOGOUT     = 4'd7;
  localparam msg_type_t TYPE_BUSINESS   = 4'd8;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE      = 2'd0;
  localparam err_code_t ERR_MISSING   = 2'd1;
  localparam err_code_t ERR_TIMEOUT   = 2'd2;
  localparam err_code_t ERR_DUPLICATE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_VALUE = 2'd1,
    ST_WAIT_CHK   = 2'd2
  } state_t;

  typedef struct packed {
    logic      done;
    logic      valid;
    err_code_t err;
    msg_type_t mtype;
  } result_t;

  // Error terminations always report an invalid message of unknown class.
  function automatic result_t error_result(input err_code_t code);
    result_t r;
    r      = '0;
    r.done = 1'b1;
    r.err  = code;
    return r;
  endfunction

endpackage

// File: rtl/fix_msgtype_classifier_if.sv
// Field-stream / checksum inputs and per-message result outputs of the classifier.
interface fix_msgtype_classifier_if #(
  parameter int unsigned VALUE_WIDTH = 256,
  parameter int unsigned CNT_WIDTH   = 16
);
  logic                   t_valid_i;
  logic [31:0]            tag_i;
  logic                   v_valid_i;
  logic [VALUE_WIDTH-1:0] value_i;
  logic                   chk_done_i;
  logic                   chk_ok_i;

  logic [3:0]             type_o;
  logic                   done_o;
  logic                   valid_o;
  logic [1:0]             err_o;
  logic [CNT_WIDTH-1:0]   msg_cnt_o;
  logic [CNT_WIDTH-1:0]   err_cnt_o;

  modport master (
    output t_valid_i, tag_i, v_valid_i, value_i, chk_done_i, chk_ok_i,
    input  type_o, done_o, valid_o, err_o, msg_cnt_o, err_cnt_o
  );

  modport slave (
    input  t_valid_i, tag_i, v_valid_i, value_i, chk_done_i, chk_ok_i,
    output type_o, done_o, valid_o, err_o, msg_cnt_o, err_cnt_o
  );
endinterface

// File: rtl/fix_msgtype_decode.sv
// Maps a right-aligned ASCII MsgType value to its message class.
module fix_msgtype_decode
  import fix_pkg::*;
#(
  parameter int unsigned VALUE_WIDTH = 256
) (
  input  logic [VALUE_WIDTH-1:0] value,
  output msg_type_t              msg_type
);

  logic single_c;

  assign single_c = (value[VALUE_WIDTH-1:8] == '0);

  always_comb begin
    msg_type = TYPE_BUSINESS;
    if (value == '0) begin
      msg_type = TYPE_UNKNOWN;
    end else if (single_c) begin
      case (value[7:0])
        8'h30:   msg_type = TYPE_HEARTBEAT;
        8'h31:   msg_type = TYPE_TEST_REQ;
        8'h32:   msg_type = TYPE_RESEND_REQ;
        8'h33:   msg_type = TYPE_REJECT;
        8'h34:   msg_type = TYPE_SEQ_RESET;
        8'h35:   msg_type = TYPE_LOGOUT;
        8'h41:   msg_type = TYPE_LOGON;
        default: msg_type = TYPE_BUSINESS;
      endcase
    end
  end

endmodule

// File: rtl/fix_msgtype_classifier.sv
// Tracks one FIX message at a time: captures the MsgType field, waits for the
// checksum verdict and emits a one-cycle classified result with statistics.
module fix_msgtype_classifier
  import fix_pkg::*;
#(
  parameter int unsigned VALUE_WIDTH    = 256,
  parameter logic [31:0] MSGTYPE_TAG    = 32'h0000_3335,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input logic                     clk,
  input logic                     rst,
  fix_msgtype_classifier_if.slave bus
);

  localparam int unsigned          TMO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_WIDTH-1:0] TMO_LAST  = TMO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  state_t               state;
  logic [TMO_WIDTH-1:0] tmo_cnt;
  logic                 dup;
  msg_type_t            ltype;
  result_t              res;
  logic [CNT_WIDTH-1:0] msg_cnt;
  logic [CNT_WIDTH-1:0] err_cnt;

  msg_type_t dec_type_c;
  result_t   emit_c;
  logic      tag_hit_c;
  logic      field_c;
  logic      timeout_c;

  fix_msgtype_decode #(.VALUE_WIDTH(VALUE_WIDTH)) u_decode (
    .value    (bus.value_i),
    .msg_type (dec_type_c)
  );

  assign tag_hit_c = bus.t_valid_i && (bus.tag_i == MSGTYPE_TAG);
  assign field_c   = bus.t_valid_i || bus.v_valid_i;
  // A cycle carrying any field is not idle, so it can never time out.
  assign timeout_c = !field_c && (tmo_cnt == TMO_LAST);

  // Result to present next cycle; checksum completion beats a timeout.
  always_comb begin
    emit_c = '0;
    case (state)
      ST_IDLE: begin
        if (bus.chk_done_i) emit_c = error_result(ERR_MISSING);
      end
      ST_WAIT_VALUE: begin
        if (bus.chk_done_i)  emit_c = error_result(ERR_MISSING);
        else if (timeout_c)  emit_c = error_result(ERR_TIMEOUT);
      end
      ST_WAIT_CHK: begin
        if (bus.chk_done_i) begin
          emit_c.done  = 1'b1;
          emit_c.mtype = ltype;
          emit_c.valid = bus.chk_ok_i && !dup && (ltype != TYPE_UNKNOWN);
          emit_c.err   = dup ? ERR_DUPLICATE : ERR_NONE;
        end else if (timeout_c) begin
          emit_c = error_result(ERR_TIMEOUT);
        end
      end
      default: emit_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
      dup     <= 1'b0;
      ltype   <= TYPE_UNKNOWN;
      res     <= '0;
      msg_cnt <= '0;
      err_cnt <= '0;
    end else begin
      res <= emit_c;

      if (emit_c.done) begin
        if (msg_cnt != CNT_MAX) msg_cnt <= msg_cnt + CNT_WIDTH'(1);
        if ((emit_c.err != ERR_NONE || !emit_c.valid) && err_cnt != CNT_MAX)
          err_cnt <= err_cnt + CNT_WIDTH'(1);
      end

      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          dup     <= 1'b0;
          ltype   <= TYPE_UNKNOWN;
          if (!bus.chk_done_i && tag_hit_c) state <= ST_WAIT_VALUE;
        end
        ST_WAIT_VALUE: begin
          tmo_cnt <= field_c ? '0 : tmo_cnt + TMO_WIDTH'(1);
          if (emit_c.done) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
          end else if (bus.v_valid_i) begin
            ltype <= dec_type_c;
            state <= ST_WAIT_CHK;
          end
        end
        ST_WAIT_CHK: begin
          tmo_cnt <= field_c ? '0 : tmo_cnt + TMO_WIDTH'(1);
          if (tag_hit_c) dup <= 1'b1;
          if (emit_c.done) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
            dup     <= 1'b0;
            ltype   <= TYPE_UNKNOWN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.done_o    = res.done;
  assign bus.valid_o   = res.valid;
  assign bus.err_o     = res.err;
  assign bus.type_o    = res.mtype;
  assign bus.msg_cnt_o = msg_cnt;
  assign bus.err_cnt_o = err_cnt;

endmodule

// File: tb/tb_fix_msgtype_classifier.sv
// Scoreboard bench for fix_msgtype_classifier: directed scenarios plus random
// field traffic checked against a message-level reference model.
module tb_fix_msgtype_classifier;

  localparam int unsigned VW    = 64;
  localparam int unsigned CW    = 4;
  localparam int unsigned TMO   = 8;
  localparam logic [31:0] TAG35 = 32'h0000_3335;
  localparam int          CMAX  = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fix_msgtype_classifier_if #(.VALUE_WIDTH(VW), .CNT_WIDTH(CW)) bus ();

  fix_msgtype_classifier #(
    .VALUE_WIDTH    (VW),
    .MSGTYPE_TAG    (TAG35),
    .TIMEOUT_CYCLES (TMO),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int due;
    int mtype;
    int valid;
    int err;
    int msgs;
    int errs;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: one open message at a time, described by what it has seen.
  bit m_open;
  bit m_have_val;
  int m_type;
  int m_idle;
  int m_dups;
  int m_msgs;
  int m_errs;

  function automatic int classify(input logic [VW-1:0] v);
    string chars = "012345A";
    int    kinds[7] = '{2, 3, 4, 5, 6, 7, 1};
    if (v == '0) return 0;
    if (v >= 256) return 8;
    for (int i = 0; i < 7; i++)
      if (v[7:0] == chars[i]) return kinds[i];
    return 8;
  endfunction

  task automatic emit(input int t, input int vl, input int e);
    exp_t x;
    if (m_msgs < CMAX) m_msgs++;
    if ((e != 0 || vl == 0) && m_errs < CMAX) m_errs++;
    x.due   = cyc + 1;
    x.mtype = t;
    x.valid = vl;
    x.err   = e;
    x.msgs  = m_msgs;
    x.errs  = m_errs;
    sb.push_back(x);
  endtask

  task automatic model_step(input bit tv, input logic [31:0] tg, input bit vv,
                            input logic [VW-1:0] val, input bit cd, input bit ok);
    bit is35 = tv && (tg == TAG35);
    if (!m_open) begin
      if (cd) emit(0, 0, 1);
      else if (is35) begin
        m_open = 1; m_have_val = 0; m_dups = 0; m_idle = 0; m_type = 0;
      end
    end else begin
      if (tv || vv) m_idle = 0;
      else m_idle++;
      if (cd) begin
        if (!m_have_val) emit(0, 0, 1);
        else emit(m_type, (ok && m_dups == 0 && m_type != 0) ? 1 : 0, (m_dups != 0) ? 3 : 0);
        m_open = 0;
      end else if (!m_have_val && vv) begin
        m_have_val = 1;
        m_type     = classify(val);
      end else if (m_idle == TMO) begin
        emit(0, 0, 2);
        m_open = 0;
      end else if (m_have_val && is35) begin
        m_dups++;
      end
    end
  endtask

  task automatic step(input bit tv, input logic [31:0] tg, input bit vv,
                      input logic [VW-1:0] val, input bit cd, input bit ok);
    bus.t_valid_i  = tv;
    bus.tag_i      = tg;
    bus.v_valid_i  = vv;
    bus.value_i    = val;
    bus.chk_done_i = cd;
    bus.chk_ok_i   = ok;
    model_step(tv, tg, vv, val, cd, ok);
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, $urandom, 1'b0, {$urandom, $urandom}, 1'b0, 1'($urandom_range(0, 1)));
  endtask
  task automatic tag_step(input logic [31:0] tg);
    step(1'b1, tg, 1'b0, '0, 1'b0, 1'b0);
  endtask
  task automatic val_step(input logic [VW-1:0] v);
    step(1'b0, '0, 1'b1, v, 1'b0, 1'b0);
  endtask
  task automatic chk_step(input bit ok);
    step(1'b0, '0, 1'b0, '0, 1'b1, ok);
  endtask

  task automatic do_reset(input int n);
    rst            = 1'b1;
    bus.t_valid_i  = 1'b0;
    bus.v_valid_i  = 1'b0;
    bus.chk_done_i = 1'b0;
    bus.chk_ok_i   = 1'b0;
    bus.tag_i      = '0;
    bus.value_i    = '0;
    repeat (n) @(negedge clk);
    check("rst_done",    bus.done_o,    0);
    check("rst_type",    bus.type_o,    0);
    check("rst_valid",   bus.valid_o,   0);
    check("rst_err",     bus.err_o,     0);
    check("rst_msg_cnt", bus.msg_cnt_o, 0);
    check("rst_err_cnt", bus.err_cnt_o, 0);
    m_open = 0; m_msgs = 0; m_errs = 0;
    rst = 1'b0;
  endtask

  task automatic dchk(input string name, input int t, input int vl, input int e, input int msgs, input int errs);
    check({name, "_done"},    bus.done_o,    1);
    check({name, "_type"},    bus.type_o,    64'(t));
    check({name, "_valid"},   bus.valid_o,   64'(vl));
    check({name, "_err"},     bus.err_o,     64'(e));
    check({name, "_msg_cnt"}, bus.msg_cnt_o, 64'(msgs));
    check({name, "_err_cnt"}, bus.err_cnt_o, 64'(errs));
  endtask

  function automatic logic [VW-1:0] rand_value();
    logic [VW-1:0] v;
    string         chars = "012345AB9Z";
    int            k     = $urandom_range(0, 9);
    v = '0;
    if (k < 7) begin
      v[7:0] = chars[$urandom_range(0, 9)];
    end else if (k < 9) begin
      v       = {$urandom, $urandom};
      v[15:8] = 8'($urandom_range(1, 255));
      v[7:0]  = chars[$urandom_range(0, 9)];
    end
    return v;
  endfunction

  // Monitor: every result pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    exp_t x;
    if (bus.done_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", bus.done_o, 0);
      end else begin
        x = sb.pop_front();
        check("done_cycle", 64'(cyc),      64'(x.due));
        check("type",       bus.type_o,    64'(x.mtype));
        check("valid",      bus.valid_o,   64'(x.valid));
        check("err",        bus.err_o,     64'(x.err));
        check("msg_cnt",    bus.msg_cnt_o, 64'(x.msgs));
        check("err_cnt",    bus.err_cnt_o, 64'(x.errs));
      end
    end else begin
      check("quiet_outputs", {bus.type_o, bus.valid_o, bus.err_o}, 0);
      if (sb.size() != 0 && sb[0].due <= cyc) begin
        void'(sb.pop_front());
        check("missing_done", bus.done_o, 1);
      end
    end
  end

  initial begin
    m_open = 0; m_have_val = 0; m_type = 0; m_idle = 0; m_dups = 0; m_msgs = 0; m_errs = 0;
    do_reset(3);

    // Logon accepted
    tag_step(TAG35); val_step(64'h41); chk_step(1'b1);
    dchk("logon", 1, 1, 0, 1, 0);
    idle_step();
    check("pulse_width", bus.done_o, 0);

    // Multi-character value is business; bad checksum invalidates it
    tag_step(TAG35); val_step(64'h4145); chk_step(1'b0);
    dchk("business", 8, 0, 0, 2, 1);

    // Checksum finishes with no MsgType seen
    chk_step(1'b1);
    dchk("missing", 0, 0, 1, 3, 2);

    // Second MsgType tag after the value
    tag_step(TAG35); val_step(64'h30); tag_step(TAG35); chk_step(1'b1);
    dchk("duplicate", 2, 0, 3, 4, 3);

    // Timeout on the eighth idle cycle, not the seventh
    tag_step(TAG35);
    repeat (7) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    check("tmo_early_done", bus.done_o, 0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    dchk("timeout", 0, 0, 2, 5, 4);

    // Checksum completion on the timeout cycle wins
    tag_step(TAG35); val_step(64'h41);
    repeat (7) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    chk_step(1'b1);
    dchk("tmo_vs_chk", 1, 1, 0, 6, 4);

    // Reset mid-message aborts silently, counters restart
    tag_step(TAG35); val_step(64'h41);
    do_reset(2);
    idle_step();
    check("abort_no_done", bus.done_o, 0);
    tag_step(TAG35); val_step(64'h41); chk_step(1'b1);
    dchk("after_rst", 1, 1, 0, 1, 0);

    // Counter saturation
    repeat (20) chk_step(1'b0);
    check("sat_msg_cnt", bus.msg_cnt_o, 64'(CMAX));
    check("sat_err_cnt", bus.err_cnt_o, 64'(CMAX));

    // Random field traffic
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 15)      tag_step(TAG35);
      else if (r < 20) tag_step($urandom);
      else if (r < 35) val_step(rand_value());
      else if (r < 45) chk_step(1'($urandom_range(0, 1)));
      else if (r < 50) repeat ($urandom_range(5, 10)) idle_step();
      else             idle_step();
    end

    repeat (12) idle_step();
    check("sb_drained", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/fix_msgtype_classifier.md
FIX_MSGTYPE_CLASSIFIER -- requirements
Module: fix_msgtype_classifier

Interface
REQ-001 SHALL have parameter VALUE_WIDTH, default 256, width of the field value bus (multiple of 8, >=16).
REQ-002 SHALL have parameter MSGTYPE_TAG, default 32'h00003335 (ASCII "35"), tag code that carries MsgType.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, the maximum number of idle cycles between fields before an open message is aborted.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, width of the statistics counters.
REQ-005 clk  in  1  clock; all logic is on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 t_valid_i  in  1  tag_i is valid this cycle.
REQ-008 tag_i  in  32  tag as right-aligned ASCII.
REQ-009 v_valid_i  in  1  value_i is valid this cycle.
REQ-010 value_i  in  VALUE_WIDTH  value as right-aligned ASCII; the last character is in [7:0] and unused upper bytes are zero.
REQ-011 chk_done_i  in  1  checksum block has finished the message.
REQ-012 chk_ok_i  in  1  checksum matched; meaningful only when chk_done_i=1.
REQ-013 type_o  out  4  message class, one of the package constants.
REQ-014 done_o  out  1  one-cycle end-of-message pulse.
REQ-015 valid_o  out  1  message accepted; meaningful only with done_o.
REQ-016 err_o  out  2  error code: 0 none, 1 missing MsgType, 2 timeout, 3 duplicate MsgType.
REQ-017 msg_cnt_o, err_cnt_o  out  CNT_WIDTH  counts of completed messages and of errored messages.

Function
REQ-018 SHALL implement a three-state FSM: IDLE, WAIT_VALUE, WAIT_CHK.
REQ-019 IDLE: t_valid_i=1 with tag_i==MSGTYPE_TAG -> WAIT_VALUE; chk_done_i=1 -> emit a done with err=1, stay in IDLE.
REQ-020 WAIT_VALUE: v_valid_i=1 -> latch the classified type, go to WAIT_CHK; chk_done_i=1 -> emit a done with err=1, go to IDLE.
REQ-021 WAIT_CHK: t_valid_i=1 with tag==MSGTYPE_TAG -> set a sticky duplicate flag; chk_done_i=1 -> emit a done, go to IDLE.
REQ-022 Classification: single-character value (value_i[VALUE_WIDTH-1:8]==0) maps '0' heartbeat, '1' test request, '2' resend request, '3' reject, '4' sequence reset, '5' logout, 'A' logon. Any other nonzero value, including multi-character values, maps to business. An all-zero value maps to unknown.
REQ-023 A done emission SHALL drive done_o=1 for exactly one cycle, on the cycle after the triggering input (one cycle of latency). All outputs SHALL be registered.
REQ-024 On a done from WAIT_CHK: type_o = latched type; valid_o = chk_ok_i AND no duplicate flag AND type!=unknown; err_o = 3 if the duplicate flag is set, else 0.
REQ-025 On an error done: valid_o=0 and type_o=unknown.
REQ-026 When done_o=0, type_o, valid_o and err_o SHALL all be 0.
REQ-027 Timeout counter: cleared on entry to IDLE and on any t_valid_i or v_valid_i; increments in WAIT_VALUE and WAIT_CHK. When it equals TIMEOUT_CYCLES-1: emit a done with err=2, go to IDLE.
REQ-028 If a timeout and chk_done_i coincide in the same cycle, chk_done_i wins.
REQ-029 msg_cnt_o SHALL increment on every done. err_cnt_o SHALL increment on every done with err_o!=0 or valid_o=0. Both counters saturate at their maximum value and do not wrap.
REQ-030 The duplicate flag and the latched type SHALL clear on entry to IDLE.

Reset
REQ-031 rst SHALL force state=IDLE and set every output, the counters, the timeout counter, the duplicate flag and the latched type to 0.
REQ-032 Reset asserted mid-message SHALL abort the message with no done pulse. The first cycle after reset SHALL be treated as IDLE.

Structure
REQ-033 A shared package fix_pkg SHALL hold the 4-bit type constants (unknown 0, logon 1, heartbeat 2, test request 3, resend request 4, reject 5, sequence reset 6, logout 7, business 8), the error-code constants and the FSM state enum.
REQ-034 Classification SHALL be a combinational sub-module fix_msgtype_decode (value in, type out), parameterised by VALUE_WIDTH.

Verification
REQ-035 Tag 0x3335, value 0x41, chk_done with ok=1 -> done_o=1 for one cycle, type=1, valid=1, err=0, msg_cnt=1.
REQ-036 Tag 0x3335, value 0x4145 ("AE"), chk_done with ok=0 -> type=8, valid=0, err=0, err_cnt=1.
REQ-037 chk_done in IDLE with no tag 35 -> done, type=0, valid=0, err=1.
REQ-038 Tag 35, value '0', tag 35 again, then chk_done ok=1 -> type=2, valid=0, err=3.
REQ-039 With TIMEOUT_CYCLES=8: tag 35, then 8 cycles with no input -> done, err=2. Variant: chk_done on the same cycle as the timeout -> err=0.
REQ-040 rst during WAIT_CHK -> no done pulse; then a full logon message -> type=1, valid=1; counters restart from 0.
